buf_packer: RTL and testbench
=============================

# buf_packer

Upstream write stage for the 16384 × 32-bit simulation buffer. Accepts a stream of 16-bit pixels (RGB555 plus spare bit) with a valid/ready handshake and packs two pixels per 32-bit word. Drives the buffer's `wren`/`data`/`address` write port with sequential addresses from 0, with frame restart, partial-word flush and overflow protection.

## Interface
Parameters:
- `ADDR_W`, default 14: buffer address width; depth = 2^ADDR_W words.
- `LAST_ADDR`, default 2^ADDR_W−1: highest writable word address.

Ports:
- `clock`, in, 1: single clock; all logic on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: pixel beat offered.
- `in_ready`, out, 1: beat accepted when `in_valid && in_ready`.
- `in_data`, in, 16: pixel.
- `in_sof`, in, 1: qualifies beat as first pixel of a frame.
- `in_flush`, in, 1: single-cycle request to write any pending half-word.
- `hold`, in, 1: harness throttle; forces `in_ready`=0.
- `wren`, out, 1: buffer write strobe (registered).
- `data`, out, 32: write word (registered); pixel N in [15:0], N+1 in [31:16].
- `address`, out, ADDR_W: write address (registered), valid while `wren`=1.
- `word_count`, out, ADDR_W+1: words written this frame.
- `full`, out, 1: `LAST_ADDR` has been written this frame.
- `overflow`, out, 1: sticky; a beat was dropped because `full`.

## Operation
- Reset values: `wren`=0, `data`=0, `address`=0, `word_count`=0, `full`=0, `overflow`=0, state IDLE, next pointer 0, `in_ready`=0 while `reset_n`=0.
- `in_ready` = !`hold` (combinational); ready in every state, including `full` (drop mode).
- States: IDLE (no frame yet), LOW (no pending half), HIGH (low half latched).
- IDLE: beats without `in_sof` are accepted and discarded. A beat with `in_sof` latches the low half → HIGH.
- Any state, accepted beat with `in_sof`: next pointer←0, `word_count`←0, `full`←0, `overflow` unchanged, pending half discarded, beat latched as low half → HIGH. Flush in the same cycle applies to the new beat (see below).
- LOW + beat (no flush): latch low half → HIGH.
- HIGH + beat: write {beat, low} at pointer → LOW.
- Flush: LOW + beat → write {16'h0, beat}, stay LOW. HIGH + beat → write {beat, low} (flush satisfied), LOW. HIGH without beat → write {16'h0, low} → LOW. LOW/IDLE without beat → no effect.
- Each write: `address`←pointer, pointer+1, `word_count`+1. Writing at `LAST_ADDR` sets `full`; pointer does not wrap.
- While `full`, writes are suppressed; any accepted non-`in_sof` beat sets `overflow`. `overflow` clears only on reset.
- At most one write per cycle.

## Timing
- Write latency: `wren` high in the cycle after the completing beat or flush is sampled; one-cycle pulse. Back-to-back pixel pairs give one write every 2 accepted beats.
- `word_count`, `full` and `address` update in the same cycle `wren` is asserted.
- `in_sof` takes effect on the beat's own edge. A write produced by the previous beat still appears (it was already registered).
- `hold` mid-pair: the pending low half is retained indefinitely.
- Asserting `reset_n` low mid-frame: all state is cleared immediately and the pending half is lost. A `wren` in flight is forced to 0 asynchronously.

## Structure
- `buf_pkg`: state enum (IDLE/LOW/HIGH), `PIX_W`=16, `WORD_W`=32 constants. Shared with the buffer read side.
- Single module, no sub-modules. Pointer/count logic inline.

## Test plan
- Reset, then `in_sof` beat 0x1111, beat 0x2222 → `wren` at addr 0, `data`=0x2222_1111, `word_count`=1.
- 8 continuous beats 0x0001..0x0008 from SOF with `hold` toggling every 3 cycles → 4 writes at addrs 0..3, `data` 0x0002_0001..0x0008_0007, no lost pixels.
- SOF, 3 beats A,B,C, then `in_flush` alone → writes {B,A} at 0, {0x0000,C} at 1. A second flush → no write.
- HIGH pending, SOF beat 0x5555 + `in_flush` same cycle → pending discarded, write {0x0000,0x5555} at addr 0, `word_count`=1.
- `LAST_ADDR`=3, 10 beats from SOF → writes at 0..3, `full`=1 after 4th, `overflow`=1 on 9th beat, no further `wren`. New SOF clears `full`, keeps `overflow`.
- Reset asserted while HIGH → `wren`=0, outputs at reset values. The next beat without SOF is discarded (IDLE).

Source files
------------

// File: rtl/buf_pkg.sv
// Shared definitions for the simulation buffer: pixel/word widths and the
// write-side packing state encoding, also used by the buffer read side.
package buf_pkg;

  localparam int PIX_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } pack_state_t;

endpackage

// File: rtl/buf_packer_if.sv
// Pixel stream handshake into the buffer packer: valid/ready beat with
// frame-start and flush qualifiers plus the harness throttle.
interface buf_packer_if;
  import buf_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             in_sof;
  logic             in_flush;
  logic             hold;

  modport master (
    output in_valid, in_data, in_sof, in_flush, hold,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_flush, hold,
    output in_ready
  );

endinterface

// File: rtl/buf_packer.sv
// Packs two 16-bit pixels per 32-bit word and drives the buffer write port
// with sequential addresses, frame restart, partial flush and drop-on-full.
//
// state | meaning
// IDLE  | no frame started yet; non-SOF beats are discarded
// LOW   | frame active, no pending half-word
// HIGH  | frame active, low half-word latched in low_q
module buf_packer
  import buf_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int LAST_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              clock,
  input  logic              reset_n,
  buf_packer_if.slave       pix,
  output logic              wren,
  output logic [WORD_W-1:0] data,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(LAST_ADDR);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  pack_state_t      state;
  logic [PIX_W-1:0] low_q;
  logic [ADDR_W:0]  ptr_q;

  logic              accept;
  logic              restart;
  logic              wr_req;
  logic [WORD_W-1:0] wr_word;
  logic [ADDR_W:0]   base_ptr;
  logic [ADDR_W:0]   base_cnt;
  logic              base_full;

  assign pix.in_ready = reset_n & ~pix.hold;
  assign accept       = pix.in_valid & pix.in_ready;
  assign restart      = accept & pix.in_sof;

  // A restarting beat sees a fresh frame: pointer, count and full all zero.
  assign base_ptr  = restart ? '0 : ptr_q;
  assign base_cnt  = restart ? '0 : word_count;
  assign base_full = restart ? 1'b0 : full;

  always_comb begin
    wr_req  = 1'b0;
    wr_word = '0;
    if (restart) begin
      if (pix.in_flush) begin
        wr_req  = 1'b1;
        wr_word = {{PIX_W{1'b0}}, pix.in_data};
      end
    end else begin
      case (state)
        LOW: begin
          if (accept && pix.in_flush) begin
            wr_req  = 1'b1;
            wr_word = {{PIX_W{1'b0}}, pix.in_data};
          end
        end
        HIGH: begin
          if (accept) begin
            wr_req  = 1'b1;
            wr_word = {pix.in_data, low_q};
          end else if (pix.in_flush) begin
            wr_req  = 1'b1;
            wr_word = {{PIX_W{1'b0}}, low_q};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      low_q      <= '0;
      ptr_q      <= '0;
      wren       <= 1'b0;
      data       <= '0;
      address    <= '0;
      word_count <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (restart) begin
        low_q <= pix.in_data;
        state <= pix.in_flush ? LOW : HIGH;
      end else begin
        case (state)
          IDLE: ;
          LOW: begin
            if (accept && !pix.in_flush) begin
              low_q <= pix.in_data;
              state <= HIGH;
            end
          end
          HIGH: begin
            if (accept || pix.in_flush) state <= LOW;
          end
          default: state <= IDLE;
        endcase
      end

      if (restart) begin
        ptr_q      <= '0;
        word_count <= '0;
        full       <= 1'b0;
      end

      if (accept && !pix.in_sof && full) overflow <= 1'b1;

      wren <= 1'b0;
      if (wr_req && !base_full) begin
        wren       <= 1'b1;
        data       <= wr_word;
        address    <= base_ptr[ADDR_W-1:0];
        ptr_q      <= base_ptr + PTR_ONE;
        word_count <= base_cnt + PTR_ONE;
        if (base_ptr == LAST_PTR) full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_buf_packer.sv
// Randomized plus directed bench for buf_packer: a default-size and a 4-word
// instance share one stimulus stream and are checked against a pixel-level model.
module tb_buf_packer;

  logic clock = 1'b0;
  logic reset_n;
  logic v = 1'b0, sof = 1'b0, fl = 1'b0, hd = 1'b0;
  logic [15:0] d = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  buf_packer_if if_b ();
  buf_packer_if if_s ();

  assign if_b.in_valid = v;   assign if_s.in_valid = v;
  assign if_b.in_data  = d;   assign if_s.in_data  = d;
  assign if_b.in_sof   = sof; assign if_s.in_sof   = sof;
  assign if_b.in_flush = fl;  assign if_s.in_flush = fl;
  assign if_b.hold     = hd;  assign if_s.hold     = hd;

  logic        b_wren, s_wren, b_full, s_full, b_ovf, s_ovf;
  logic [31:0] b_data, s_data;
  logic [13:0] b_addr;
  logic [1:0]  s_addr;
  logic [14:0] b_cnt;
  logic [2:0]  s_cnt;

  buf_packer u_big (
    .clock(clock), .reset_n(reset_n), .pix(if_b),
    .wren(b_wren), .data(b_data), .address(b_addr),
    .word_count(b_cnt), .full(b_full), .overflow(b_ovf)
  );

  buf_packer #(.ADDR_W(2), .LAST_ADDR(3)) u_small (
    .clock(clock), .reset_n(reset_n), .pix(if_s),
    .wren(s_wren), .data(s_data), .address(s_addr),
    .word_count(s_cnt), .full(s_full), .overflow(s_ovf)
  );

  // Model: per instance, whether a frame is open, the unpaired pixel (if any),
  // next word address, words this frame, and the last registered write.
  int       last_a [2] = '{16383, 3};
  bit       in_frame [2];
  bit       have [2];
  bit [15:0] pend [2];
  bit       m_full [2];
  bit       m_ovf [2];
  bit       m_wren [2];
  bit [31:0] m_data [2];
  int       m_addr [2];
  int       m_ptr [2];
  int       m_cnt [2];

  task automatic model_clear(int k);
    in_frame[k] = 0; have[k] = 0; pend[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
    m_wren[k] = 0; m_data[k] = 0; m_addr[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
  endtask

  task automatic model_step(int k);
    bit acc, w;
    bit [31:0] wd;
    acc = v && !hd;
    w = 0;
    wd = 0;
    m_wren[k] = 0;
    if (acc && sof) begin
      in_frame[k] = 1; have[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_full[k] = 0;
    end
    if (acc && in_frame[k]) begin
      if (m_full[k] && !sof) m_ovf[k] = 1;
      if (have[k]) begin
        w = 1; wd = {d, pend[k]}; have[k] = 0;
      end else if (fl) begin
        w = 1; wd = {16'h0000, d};
      end else begin
        have[k] = 1; pend[k] = d;
      end
    end else if (!acc && fl && have[k]) begin
      w = 1; wd = {16'h0000, pend[k]}; have[k] = 0;
    end
    if (w && !m_full[k]) begin
      m_wren[k] = 1;
      m_data[k] = wd;
      m_addr[k] = m_ptr[k];
      if (m_ptr[k] == last_a[k]) m_full[k] = 1;
      m_ptr[k]++;
      m_cnt[k]++;
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    cmp("b.in_ready", 64'(if_b.in_ready), 64'(reset_n && !hd));
    cmp("s.in_ready", 64'(if_s.in_ready), 64'(reset_n && !hd));
    cmp("b.wren", 64'(b_wren), 64'(m_wren[0]));
    cmp("s.wren", 64'(s_wren), 64'(m_wren[1]));
    cmp("b.data", 64'(b_data), 64'(m_data[0]));
    cmp("s.data", 64'(s_data), 64'(m_data[1]));
    cmp("b.address", 64'(b_addr), 64'(m_addr[0]));
    cmp("s.address", 64'(s_addr), 64'(m_addr[1]));
    cmp("b.word_count", 64'(b_cnt), 64'(m_cnt[0]));
    cmp("s.word_count", 64'(s_cnt), 64'(m_cnt[1]));
    cmp("b.full", 64'(b_full), 64'(m_full[0]));
    cmp("s.full", 64'(s_full), 64'(m_full[1]));
    cmp("b.overflow", 64'(b_ovf), 64'(m_ovf[0]));
    cmp("s.overflow", 64'(s_ovf), 64'(m_ovf[1]));
  end

  task automatic step(bit vv, bit [15:0] dd, bit ss, bit ff, bit hh);
    @(negedge clock);
    #2;
    v = vv; d = dd; sof = ss; fl = ff; hd = hh;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit [31:0] wd_log [8];
    int        wa_log [8];
    int        nw, pix, cyc;
    bit        hh, rst_now;

    reset_n = 1'b0;
    #1;
    cmp("reset wren", 64'(b_wren), 64'd0);
    cmp("reset in_ready", 64'(if_b.in_ready), 64'd0);
    cmp("reset word_count", 64'(b_cnt), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;

    // First pair after reset
    step(1, 16'h1111, 1, 0, 0);
    step(1, 16'h2222, 0, 0, 0);
    after_edge();
    cmp("pair wren", 64'(b_wren), 64'd1);
    cmp("pair data", 64'(b_data), 64'h2222_1111);
    cmp("pair address", 64'(b_addr), 64'd0);
    cmp("pair word_count", 64'(b_cnt), 64'd1);
    step(0, 16'h0, 0, 0, 0);
    after_edge();
    cmp("pair pulse", 64'(b_wren), 64'd0);

    // Eight beats under a hold that toggles every 3 cycles
    nw = 0; pix = 1; cyc = 0;
    while ((pix <= 8 || cyc < 40) && cyc < 60) begin
      hh = ((cyc / 3) % 2) == 1;
      if (pix <= 8) step(1, 16'(pix), pix == 1, 0, hh);
      else          step(0, 16'h0, 0, 0, hh);
      if (pix <= 8 && !hh) pix++;
      after_edge();
      if (b_wren && nw < 8) begin
        wd_log[nw] = b_data; wa_log[nw] = int'(b_addr); nw++;
      end
      cyc++;
    end
    cmp("hold write count", 64'(nw), 64'd4);
    for (int i = 0; i < 4; i++) begin
      cmp("hold data", 64'(wd_log[i]), 64'(((2*i+2) << 16) | (2*i+1)));
      cmp("hold address", 64'(wa_log[i]), 64'(i));
    end

    // Partial word flush, then a redundant flush
    step(1, 16'h000A, 1, 0, 0);
    step(1, 16'h000B, 0, 0, 0);
    after_edge();
    cmp("flush pair data", 64'(b_data), 64'h000B_000A);
    step(1, 16'h000C, 0, 0, 0);
    after_edge();
    cmp("flush pending no wren", 64'(b_wren), 64'd0);
    step(0, 16'h0, 0, 1, 0);
    after_edge();
    cmp("flush wren", 64'(b_wren), 64'd1);
    cmp("flush data", 64'(b_data), 64'h0000_000C);
    cmp("flush address", 64'(b_addr), 64'd1);
    cmp("flush word_count", 64'(b_cnt), 64'd2);
    step(0, 16'h0, 0, 1, 0);
    after_edge();
    cmp("second flush", 64'(b_wren), 64'd0);

    // SOF + flush while a half is pending
    step(1, 16'h1234, 1, 0, 0);
    step(1, 16'h5555, 1, 1, 0);
    after_edge();
    cmp("sof flush wren", 64'(b_wren), 64'd1);
    cmp("sof flush data", 64'(b_data), 64'h0000_5555);
    cmp("sof flush address", 64'(b_addr), 64'd0);
    cmp("sof flush word_count", 64'(b_cnt), 64'd1);

    // Fill the 4-word instance with 10 beats
    for (int i = 1; i <= 10; i++) begin
      step(1, 16'(i), i == 1, 0, 0);
      after_edge();
      if (i == 8) begin
        cmp("small last wren", 64'(s_wren), 64'd1);
        cmp("small last address", 64'(s_addr), 64'd3);
        cmp("small last data", 64'(s_data), 64'h0008_0007);
        cmp("small full", 64'(s_full), 64'd1);
        cmp("small ovf before", 64'(s_ovf), 64'd0);
      end
      if (i == 9) cmp("small ovf", 64'(s_ovf), 64'd1);
      if (i >= 9) cmp("small no wren", 64'(s_wren), 64'd0);
    end
    cmp("big not full", 64'(b_full), 64'd0);
    step(1, 16'h00AA, 1, 0, 0);
    after_edge();
    cmp("sof clears full", 64'(s_full), 64'd0);
    cmp("sof keeps ovf", 64'(s_ovf), 64'd1);
    cmp("sof clears count", 64'(s_cnt), 64'd0);

    // Asynchronous reset with a write in flight
    step(1, 16'h0BBB, 0, 0, 0);
    after_edge();
    cmp("pre-reset wren", 64'(b_wren), 64'd1);
    reset_n = 1'b0;
    #1;
    cmp("async wren", 64'(b_wren), 64'd0);
    cmp("async data", 64'(b_data), 64'd0);
    cmp("async ovf", 64'(s_ovf), 64'd0);
    step(0, 16'h0, 0, 0, 0);
    reset_n = 1'b1;

    // Reset while HIGH; following beats without SOF are discarded
    step(1, 16'h0777, 1, 0, 0);
    after_edge();
    reset_n = 1'b0;
    #1;
    cmp("reset in HIGH count", 64'(b_cnt), 64'd0);
    step(0, 16'h0, 0, 0, 0);
    reset_n = 1'b1;
    step(1, 16'h3333, 0, 0, 0);
    step(1, 16'h4444, 0, 0, 0);
    after_edge();
    cmp("idle discard wren", 64'(b_wren), 64'd0);
    cmp("idle discard count", 64'(b_cnt), 64'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst_now = ($urandom_range(0, 599) == 0);
      @(negedge clock);
      #2;
      reset_n = !rst_now;
      v   = ($urandom_range(0, 3) != 0);
      d   = 16'($urandom);
      sof = ($urandom_range(0, 39) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      hd  = ($urandom_range(0, 3) == 0);
    end
    step(0, 16'h0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
